// File: rtl/register_shift_reader.sv
// register_shift_reader
// Unload side of the 16-bit register datapath. Captures a parallel word on
// start and streams it MSB first over a valid/ready serial handshake.
//
// Ports:
//   clock      rising-edge clock
//   reset      synchronous, active-high reset
//   start      capture data_in and begin streaming (sampled only in IDLE)
//   data_in    parallel word to unload
//   idle       high in IDLE, able to accept start
//   ser_out    current serial bit, meaningful while ser_valid=1
//   ser_valid  ser_out holds a valid beat
//   ser_ready  consumer accepts the current beat when ser_valid & ser_ready
//   ser_last   final beat of the word
//   done       one-cycle pulse after the final beat is accepted
//
// Build option: define REG_READER_PARITY_EN to append an even-parity beat
// (XOR of the captured word) after bit 0; ser_last then moves to that beat.
module register_shift_reader #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             idle,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_last,
  output logic             done
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;
`ifdef REG_READER_PARITY_EN
  localparam logic [1:0] ST_PARITY = 2'd3;
`endif

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [1:0]       state,  state_n;
  logic [WIDTH-1:0] shreg,  shreg_n;
  logic [CNT_W-1:0] cnt,    cnt_n;
`ifdef REG_READER_PARITY_EN
  logic             par_q,  par_n;
`endif

  logic idle_n, ser_out_n, ser_valid_n, ser_last_n, done_n;
  logic beat_ok;

  // State, datapath and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      cnt       <= '0;
`ifdef REG_READER_PARITY_EN
      par_q     <= 1'b0;
`endif
      idle      <= 1'b1;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      ser_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      cnt       <= cnt_n;
`ifdef REG_READER_PARITY_EN
      par_q     <= par_n;
`endif
      idle      <= idle_n;
      ser_out   <= ser_out_n;
      ser_valid <= ser_valid_n;
      ser_last  <= ser_last_n;
      done      <= done_n;
    end
  end

  // Next-state, datapath update and next output values
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n   = cnt;
`ifdef REG_READER_PARITY_EN
    par_n   = par_q;
`endif
    beat_ok = ser_valid & ser_ready;

    case (state)
      ST_IDLE: begin
        if (start) begin
          shreg_n = data_in;
          cnt_n   = '0;
`ifdef REG_READER_PARITY_EN
          par_n   = ^data_in;
`endif
          state_n = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (beat_ok) begin
          shreg_n = {shreg[WIDTH-2:0], 1'b0};
          cnt_n   = cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
`ifdef REG_READER_PARITY_EN
            state_n = ST_PARITY;
`else
            state_n = ST_DONE;
`endif
          end
        end
      end
`ifdef REG_READER_PARITY_EN
      ST_PARITY: begin
        if (beat_ok) state_n = ST_DONE;
      end
`endif
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase

    // Outputs are registered copies of what the next state will present,
    // so they line up with the state flops without a decode stage.
    idle_n      = (state_n == ST_IDLE);
    done_n      = (state_n == ST_DONE);
`ifdef REG_READER_PARITY_EN
    ser_valid_n = (state_n == ST_SHIFT) || (state_n == ST_PARITY);
    ser_last_n  = (state_n == ST_PARITY);
    if (state_n == ST_SHIFT)       ser_out_n = shreg_n[WIDTH-1];
    else if (state_n == ST_PARITY) ser_out_n = par_n;
    else                           ser_out_n = 1'b0;
`else
    ser_valid_n = (state_n == ST_SHIFT);
    ser_last_n  = (state_n == ST_SHIFT) && (cnt_n == LAST_CNT);
    ser_out_n   = (state_n == ST_SHIFT) ? shreg_n[WIDTH-1] : 1'b0;
`endif
  end

endmodule

// File: tb/tb_register_shift_reader.sv
// Directed bench for register_shift_reader with a beat scoreboard.
module tb_register_shift_reader;

`ifdef REG_READER_PARITY_EN
  localparam int BEATS = 17;
`else
  localparam int BEATS = 16;
`endif

  logic        clock;
  logic        reset;
  logic        start;
  logic [15:0] data_in;
  logic        idle;
  logic        ser_out;
  logic        ser_valid;
  logic        ser_ready;
  logic        ser_last;
  logic        done;

  int total = 0;
  int bad   = 0;

  // Expected beats: {bit, last}
  logic [1:0] sb[$];

  register_shift_reader dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .data_in   (data_in),
    .idle      (idle),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .ser_ready (ser_ready),
    .ser_last  (ser_last),
    .done      (done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [15:0] d);
    for (int i = 15; i >= 0; i--) begin
`ifdef REG_READER_PARITY_EN
      sb.push_back({d[i], 1'b0});
`else
      sb.push_back({d[i], (i == 0)});
`endif
    end
`ifdef REG_READER_PARITY_EN
    sb.push_back({^d, 1'b1});
`endif
  endtask

  // Pop one expected beat and compare with what the DUT presents now.
  task automatic score_beat();
    logic [1:0] e;
    check("sb_nonempty", (sb.size() > 0), 1'b1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("beat_bit", ser_out, e[1]);
      check("beat_last", ser_last, e[0]);
    end
  endtask

  // Capture d and stream it; stall slen cycles after acceptance s1 and s2.
  // poke re-pulses start and changes data_in while the word is in flight.
  task automatic run_word(input logic [15:0] d, input int s1, input int s2,
                          input int slen, input logic poke);
    int   acc, stall, exp_done, last_acc;
    logic got_done, prev_stall, prev_bit;
    @(negedge clock);
    check("idle_pre", idle, 1'b1);
    data_in = d; start = 1'b1; ser_ready = 1'b1;
    push_word(d);
    acc = 0; stall = 0; got_done = 1'b0; prev_stall = 1'b0; prev_bit = 1'b0;
    last_acc = -1;
    exp_done = BEATS + ((s1 > 0) ? slen : 0) + ((s2 > 0) ? slen : 0);
    for (int cyc = 0; cyc < 200 && !got_done; cyc++) begin
      @(negedge clock);
      if (cyc == 0) begin
        start = 1'b0;
        check("valid_first", ser_valid, 1'b1);
      end
      if (poke) begin
        data_in = 16'hFFFF;
        start   = (cyc % 4 == 1);
      end
      if (done) begin
        got_done = 1'b1;
        start    = 1'b0;
        check("done_latency", cyc, exp_done);
        check("done_after_last", cyc, last_acc + 1);
        check("beats_accepted", acc, BEATS);
        check("sb_empty", sb.size(), 0);
        check("valid_in_done", ser_valid, 1'b0);
        check("idle_in_done", idle, 1'b0);
      end else begin
        if (stall > 0) begin
          ser_ready = 1'b0;
          stall--;
        end else begin
          ser_ready = 1'b1;
        end
        if (prev_stall) check("stall_stable", ser_out, prev_bit);
        if (ser_valid && ser_ready) begin
          score_beat();
          acc++;
          last_acc = cyc;
          if (acc == s1 || acc == s2) stall = slen;
        end
        prev_stall = ser_valid && !ser_ready;
        prev_bit   = ser_out;
      end
    end
    if (!got_done) check("done_timeout", got_done, 1'b1);
    @(negedge clock);
    check("done_one_cycle", done, 1'b0);
    check("idle_back", idle, 1'b1);
    check("valid_after", ser_valid, 1'b0);
    if (poke) begin
      repeat (2) begin
        @(negedge clock);
        check("no_second_word", ser_valid, 1'b0);
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; data_in = 16'h0000; ser_ready = 1'b0;

    // Reset then idle
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_idle", idle, 1'b1);
    check("rst_valid", ser_valid, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ser_out", ser_out, 1'b0);
    check("rst_last", ser_last, 1'b0);

    // Basic stream, backpressure, ignored start with data change
    run_word(16'hA5C3, 0, 0, 0, 1'b0);
    run_word(16'h8001, 1, 8, 3, 1'b0);
    run_word(16'h1357, 0, 0, 0, 1'b1);

    // Mid-word reset after 5 accepted beats
    @(negedge clock);
    data_in = 16'h1234; start = 1'b1; ser_ready = 1'b1;
    push_word(16'h1234);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      start = 1'b0;
      score_beat();
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_idle", idle, 1'b1);
    check("abort_valid", ser_valid, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_ser_out", ser_out, 1'b0);
    sb.delete();
    repeat (3) begin
      @(negedge clock);
      check("abort_no_done", done, 1'b0);
    end
    run_word(16'h00FF, 0, 0, 0, 1'b0);

`ifdef REG_READER_PARITY_EN
    run_word(16'h0007, 0, 0, 0, 1'b0);
    run_word(16'h0003, 3, 0, 2, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
